digit_serial_addsub: RTL and testbench
======================================

// Module: digit_serial_addsub
//
// PURPOSE
//   Parametrised multi-cycle adder/subtractor, successor to the fixed 8-bit combinational ripple adder.
//   Processes DIGIT bits per clock over WIDTH/DIGIT cycles, which trades latency for a small carry chain.
//   Uses a start/ready/done handshake and adds a subtract mode and a signed-overflow flag.
//   Intended as the arithmetic unit under a lab datapath controller.
//
// PARAMETERS
//   WIDTH  8  operand/result width in bits; must be a multiple of DIGIT
//   DIGIT  2  bits processed per cycle; N = WIDTH/DIGIT digit cycles (N >= 1)
//
// PORTS
//   clk    in   1      clock; all state changes on the rising edge
//   rst_n  in   1      synchronous active-low reset
//   start  in   1      request; accepted only when ready=1
//   mode   in   1      0: s = a + b + cin;  1: s = a - b - cin (borrow-in)
//   a      in   WIDTH  operand A, sampled on the accept edge only
//   b      in   WIDTH  operand B, sampled on the accept edge only
//   cin    in   1      carry-in (add) or borrow-in (sub), sampled on the accept edge
//   ready  out  1      1 in IDLE only
//   done   out  1      single-cycle pulse; result valid
//   s      out  WIDTH  result; held until the next completion
//   cout   out  1      carry-out; in sub mode 1 = no borrow
//   ovf    out  1      two's-complement overflow (carry into MSB XOR carry out of MSB)
//
// BEHAVIOUR
//   Reset (rst_n=0 at edge): state=IDLE, ready=1, done=0, s=0, cout=0, ovf=0, digit count=0.
//     Reset wins over every other input. It aborts an operation in flight; no done is produced.
//   States: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: ready=1. At the edge where start=1:
//     - latch a, mode ? ~b : b, and carry = cin ^ mode
//     - clear count, go to RUN
//   RUN: ready=0. Each edge adds digit[count] of the latched operands plus carry (LSB digit first).
//     - stores the DIGIT-bit sum, updates carry, increments count
//     - on the edge that processes digit N-1: s, cout and ovf load together; go to DONE
//   DONE: done=1 and ready=0 for exactly one cycle; the next edge returns to IDLE.
//   Latency: accept at edge E0; done is high in the cycle after edge EN; ready returns after E(N+1).
//     Back-to-back ops: one op every N+2 cycles.
//   start while ready=0 (RUN or DONE) is ignored and not queued.
//     a, b, cin and mode changing after the accept edge do not affect the result.
//   s, cout and ovf change only at completion or reset; they are not disturbed during RUN.
//   All arithmetic is modulo 2^WIDTH; cout is bit WIDTH of the full sum.
//   N = 1 (DIGIT = WIDTH) is legal: a single RUN cycle.
//
// TESTING (default WIDTH=8, DIGIT=2, N=4 unless stated)
//   1. reset, then start a=0x0F b=0x01 cin=0 mode=0 -> after 4 cycles done=1, s=0x10, cout=0, ovf=0
//   2. a=0xFF b=0x01 cin=1 mode=0 -> s=0x01, cout=1, ovf=0; a=0x7F b=0x01 -> s=0x80, cout=0, ovf=1
//   3. mode=1: a=0x05 b=0x07 cin=0 -> s=0xFE, cout=0, ovf=0; a=0x80 b=0x01 -> s=0x7F, cout=1, ovf=1
//   4. start re-asserted and a changed to 0xAA during RUN -> ignored; ready stays 0; done once with original result
//   5. rst_n=0 for one cycle mid-RUN -> ready=1, s=0, cout=0, ovf=0 next cycle; no done pulse
//   6. re-run 1-3 with WIDTH=16/DIGIT=4 and WIDTH=8/DIGIT=8 -> results match a+b+cin reference; done at N cycles

Source files
------------

// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: processes DIGIT bits per cycle, with a signed-overflow flag.
// Latency: the operation is accepted at edge E0, done pulses in the cycle after edge EN (N = WIDTH/DIGIT).
// Backpressure: start is taken only while ready=1; requests while busy are dropped, not queued.
module digit_serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last;
    logic [DIGIT:0]   dsum;
    logic             msb_carry_in;

    assign last = (cnt == CW'(N - 1));

    // Operands shift right each RUN cycle, so the active digit is always the low DIGIT bits.
    assign dsum = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};

    // Result digits enter at the top of acc; after N shifts acc holds the full sum.
    assign acc_nxt = (acc >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));

    assign msb_carry_in = op_a[DIGIT-1] ^ op_b[DIGIT-1] ^ dsum[DIGIT-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + ~borrow_in.
                        op_a  <= a;
                        op_b  <= mode ? ~b : b;
                        carry <= cin ^ mode;
                        cnt   <= '0;
                        acc   <= '0;
                    end
                end
                ST_RUN: begin
                    op_a  <= op_a >> DIGIT;
                    op_b  <= op_b >> DIGIT;
                    acc   <= acc_nxt;
                    carry <= dsum[DIGIT];
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        s    <= acc_nxt;
                        cout <= dsum[DIGIT];
                        ovf  <= msb_carry_in ^ dsum[DIGIT];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Bench for digit_serial_addsub: three instances (8/2, 16/4, 8/8) checked through a result scoreboard.
module tb_digit_serial_addsub;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic        cin;
    logic [15:0] a16;
    logic [15:0] b16;
    logic [2:0]  start_v;
    logic [2:0]  ready_v;
    logic [2:0]  done_v;
    logic [2:0]  cout_v;
    logic [2:0]  ovf_v;
    logic [7:0]  s0;
    logic [15:0] s1;
    logic [7:0]  s2;

    int          n_checks;
    int          n_pass;
    int          done_cnt [3];
    logic [17:0] q0 [$];
    logic [17:0] q1 [$];
    logic [17:0] q2 [$];

    digit_serial_addsub #(.WIDTH(8), .DIGIT(2)) u_d0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .mode(mode),
        .a(a16[7:0]), .b(b16[7:0]), .cin(cin),
        .ready(ready_v[0]), .done(done_v[0]), .s(s0), .cout(cout_v[0]), .ovf(ovf_v[0])
    );

    digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .mode(mode),
        .a(a16), .b(b16), .cin(cin),
        .ready(ready_v[1]), .done(done_v[1]), .s(s1), .cout(cout_v[1]), .ovf(ovf_v[1])
    );

    digit_serial_addsub #(.WIDTH(8), .DIGIT(8)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .mode(mode),
        .a(a16[7:0]), .b(b16[7:0]), .cin(cin),
        .ready(ready_v[2]), .done(done_v[2]), .s(s2), .cout(cout_v[2]), .ovf(ovf_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int width_of(input int i);
        return (i == 1) ? 16 : 8;
    endfunction

    function automatic int lat_of(input int i);
        return (i == 2) ? 1 : 4;
    endfunction

    // Independent full-width reference: {ovf, cout, s}.
    function automatic logic [17:0] ref_op(input int w, input logic [15:0] av, input logic [15:0] bv,
                                           input logic cv, input logic mv);
        logic [15:0] mask;
        logic [15:0] bb;
        logic [16:0] full;
        logic        co;
        logic        cm;
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        bb   = (mv ? ~bv : bv) & mask;
        full = {1'b0, av & mask} + {1'b0, bb} + {16'b0, cv ^ mv};
        co   = full[w];
        cm   = av[w-1] ^ bb[w-1] ^ full[w-1];
        return {cm ^ co, co, full[15:0] & mask};
    endfunction

    function automatic logic [17:0] dut_res(input int i);
        case (i)
            0:       return {ovf_v[0], cout_v[0], 8'h00, s0};
            1:       return {ovf_v[1], cout_v[1], s1};
            default: return {ovf_v[2], cout_v[2], 8'h00, s2};
        endcase
    endfunction

    task automatic push_exp(input int i, input logic [17:0] e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done_v[i]) begin
                logic [17:0] e;
                int          sz;
                done_cnt[i]++;
                sz = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
                if (sz == 0) begin
                    check($sformatf("unexpected_done%0d", i), 32'd1, 32'd0);
                end else begin
                    case (i)
                        0:       e = q0.pop_front();
                        1:       e = q1.pop_front();
                        default: e = q2.pop_front();
                    endcase
                    check($sformatf("result%0d", i), 32'(dut_res(i)), 32'(e));
                end
            end
        end
    end

    task automatic wait_ready(input int i);
        int k;
        k = 0;
        @(negedge clk);
        while (!ready_v[i] && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!ready_v[i]) check($sformatf("ready_timeout%0d", i), 32'd0, 32'd1);
    endtask

    task automatic run_op(input int i, input logic [15:0] av, input logic [15:0] bv,
                          input logic cv, input logic mv, input logic [17:0] e);
        int cyc;
        bit seen;
        wait_ready(i);
        a16        = av;
        b16        = bv;
        cin        = cv;
        mode       = mv;
        start_v[i] = 1'b1;
        push_exp(i, e);
        @(posedge clk);
        #1;
        start_v[i] = 1'b0;
        a16        = 16'($urandom);
        b16        = 16'($urandom);
        cin        = ~cv;
        mode       = ~mv;
        cyc        = 0;
        seen       = 1'b0;
        while (!seen && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done_v[i]) seen = 1'b1;
        end
        check($sformatf("latency%0d", i), 32'(cyc), 32'(lat_of(i)));
        check($sformatf("ready_in_done%0d", i), 32'(ready_v[i]), 32'd0);
    endtask

    typedef struct {
        logic [15:0] av;
        logic [15:0] bv;
        logic        cv;
        logic        mv;
        logic [17:0] e8;
    } vec_t;

    vec_t tbl [5];
    int   base;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < 3; i++) done_cnt[i] = 0;
        rst_n   = 1'b0;
        start_v = 3'b000;
        mode    = 1'b0;
        cin     = 1'b0;
        a16     = 16'h0;
        b16     = 16'h0;

        // {ovf, cout, s} constants for the 8-bit cases.
        tbl[0] = '{16'h000F, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0010}};
        tbl[1] = '{16'h00FF, 16'h0001, 1'b1, 1'b0, {1'b0, 1'b1, 16'h0001}};
        tbl[2] = '{16'h007F, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0080}};
        tbl[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'h00FE}};
        tbl[4] = '{16'h0080, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h007F}};

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_ready", 32'(ready_v), 32'h7);
        check("reset_done", 32'(done_v), 32'h0);
        check("reset_s0", 32'(s0), 32'h0);
        check("reset_cout0", 32'(cout_v[0]), 32'h0);
        check("reset_ovf0", 32'(ovf_v[0]), 32'h0);

        for (int k = 0; k < 5; k++) begin
            run_op(0, tbl[k].av, tbl[k].bv, tbl[k].cv, tbl[k].mv, tbl[k].e8);
        end

        // Start re-asserted with a new operand during RUN must be ignored.
        wait_ready(0);
        a16        = 16'h000F;
        b16        = 16'h0001;
        cin        = 1'b0;
        mode       = 1'b0;
        start_v[0] = 1'b1;
        push_exp(0, {1'b0, 1'b0, 16'h0010});
        @(posedge clk);
        #1;
        base = done_cnt[0];
        a16  = 16'h00AA;
        repeat (2) begin
            @(negedge clk);
            check("busy_ready", 32'(ready_v[0]), 32'd0);
        end
        start_v[0] = 1'b0;
        repeat (8) @(negedge clk);
        check("single_done", 32'(done_cnt[0] - base), 32'd1);

        // Reset mid-RUN aborts the operation without a done pulse.
        wait_ready(0);
        a16        = 16'h0033;
        b16        = 16'h0011;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        base       = done_cnt[0];
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready", 32'(ready_v[0]), 32'd1);
        check("abort_s0", 32'(s0), 32'h0);
        check("abort_cout0", 32'(cout_v[0]), 32'h0);
        check("abort_ovf0", 32'(ovf_v[0]), 32'h0);
        repeat (8) @(negedge clk);
        check("abort_no_done", 32'(done_cnt[0] - base), 32'd0);

        for (int i = 1; i < 3; i++) begin
            for (int k = 0; k < 5; k++) begin
                logic [15:0] av;
                logic [15:0] bv;
                av = tbl[k].av;
                bv = tbl[k].bv;
                if (i == 1) begin
                    av = {av[7:0], av[7:0]};
                    bv = {8'h00, bv[7:0]};
                end
                run_op(i, av, bv, tbl[k].cv, tbl[k].mv, ref_op(width_of(i), av, bv, tbl[k].cv, tbl[k].mv));
            end
        end

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 3; i++) begin
                logic [15:0] av;
                logic [15:0] bv;
                logic        cv;
                logic        mv;
                av = 16'($urandom);
                bv = 16'($urandom);
                cv = 1'($urandom_range(1));
                mv = 1'($urandom_range(1));
                if (width_of(i) == 8) begin
                    av[15:8] = 8'h00;
                    bv[15:8] = 8'h00;
                end
                run_op(i, av, bv, cv, mv, ref_op(width_of(i), av, bv, cv, mv));
            end
        end

        repeat (4) @(negedge clk);
        check("sb_empty0", 32'(q0.size()), 32'd0);
        check("sb_empty1", 32'(q1.size()), 32'd0);
        check("sb_empty2", 32'(q2.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
